// File: rtl/csi2_data_types_pkg.sv
// Shared CSI-2 data-type codes, header layout and payload extractor FSM states.
package csi2_data_types_pkg;

  localparam logic [5:0] FRAME_START = 6'h00;
  localparam logic [5:0] FRAME_END   = 6'h01;
  localparam logic [5:0] LINE_START  = 6'h02;
  localparam logic [5:0] LINE_END    = 6'h03;
  localparam logic [5:0] RAW8        = 6'h2A;
  localparam logic [5:0] RAW10       = 6'h2B;
  localparam logic [5:0] RAW12       = 6'h2C;

  localparam logic [15:0] CRC_POLY = 16'h8408;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef struct packed {
    logic [7:0]  ecc;
    logic [15:0] wc;
    logic [1:0]  vc;
    logic [5:0]  dt;
  } csi2_header_t;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

endpackage

// File: rtl/axi4_stream_if.sv
// 32-bit AXI4-Stream bundle used for both the packet input and the pixel output.
interface axi4_stream_if;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic [0:0]  tuser;

  modport master (output tdata, tstrb, tkeep, tlast, tvalid, tuser, input tready);
  modport slave  (input tdata, tstrb, tkeep, tlast, tvalid, tuser, output tready);
endinterface

// File: rtl/csi2_crc16.sv
// CSI-2 CRC-16 update over up to four bytes of a beat, lowest byte first.
module csi2_crc16
  import csi2_data_types_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  byte_en_i,
  output logic [15:0] crc_o
);

  logic [15:0] c;

  always_comb begin
    c = crc_i;
    for (int b = 0; b < 4; b++) begin
      if (byte_en_i[b]) begin
        c = c ^ {8'h00, data_i[8*b +: 8]};
        for (int k = 0; k < 8; k++) begin
          c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
      end
    end
    crc_o = c;
  end

endmodule

// File: rtl/csi2_payload_extractor.sv
// Strips CSI-2 headers and CRC footers, checks payload CRC and emits pixel beats
// with start-of-frame (tuser) and end-of-line (tlast) markers.
module csi2_payload_extractor
  import csi2_data_types_pkg::*;
#(
  parameter logic [5:0] ACCEPT_DT = RAW10,
  parameter bit         CHECK_CRC = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  axi4_stream_if.slave  pkt_i,
  axi4_stream_if.master video_o,
  output logic         frame_active_o,
  output logic [15:0]  line_cnt_o,
  output logic         crc_err_o,
  output logic         len_err_o
);

  state_t       state, state_next;
  csi2_header_t hdr;
  logic [15:0]  bytes_left, bytes_left_nx;
  logic [15:0]  crc_reg, crc_calc;
  logic [15:0]  crc_rx, crc_rx_nx;
  logic [1:0]   crc_cnt, crc_cnt_nx;
  logic [15:0]  line_count;
  logic         sof_pending;
  logic [2:0]   n_data;
  logic [3:0]   data_en;
  logic         hdr_beat, pay_beat, beat_out, out_last, short_pkt, crc_bad;
  logic         unused_ok;

  assign pkt_i.tready = 1'b1;
  assign hdr          = csi2_header_t'(pkt_i.tdata);
  assign hdr_beat     = pkt_i.tvalid && (state == ST_HDR);
  assign pay_beat     = pkt_i.tvalid && (state == ST_PAYLOAD);
  assign unused_ok    = ^{pkt_i.tstrb, pkt_i.tkeep, pkt_i.tuser, video_o.tready, hdr.ecc, hdr.vc};

  csi2_crc16 u_crc (
    .crc_i     (crc_reg),
    .data_i    (pkt_i.tdata),
    .byte_en_i (data_en),
    .crc_o     (crc_calc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_HDR;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (pkt_i.tvalid) begin
      case (state)
        ST_HDR: begin
          if (!pkt_i.tlast) state_next = (hdr.dt == ACCEPT_DT) ? ST_PAYLOAD : ST_DROP;
        end
        ST_PAYLOAD, ST_DROP: begin
          if (pkt_i.tlast) state_next = ST_HDR;
        end
        default: state_next = ST_HDR;
      endcase
    end
  end

  // Lanes past the remaining word count carry the CRC footer, low byte first.
  always_comb begin
    n_data     = (bytes_left > 16'd4) ? 3'd4 : bytes_left[2:0];
    data_en    = '0;
    crc_rx_nx  = crc_rx;
    crc_cnt_nx = crc_cnt;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < n_data) begin
        data_en[i] = 1'b1;
      end else begin
        if (crc_cnt_nx == 2'd0)      crc_rx_nx[7:0]  = pkt_i.tdata[8*i +: 8];
        else if (crc_cnt_nx == 2'd1) crc_rx_nx[15:8] = pkt_i.tdata[8*i +: 8];
        if (crc_cnt_nx != 2'd2) crc_cnt_nx = crc_cnt_nx + 2'd1;
      end
    end
    bytes_left_nx = bytes_left - 16'(n_data);
    short_pkt     = (bytes_left_nx != 16'd0) || (crc_cnt_nx != 2'd2);
    beat_out      = pay_beat && (n_data != 3'd0);
    out_last      = (bytes_left_nx == 16'd0) || (pkt_i.tlast && short_pkt);
    crc_bad       = CHECK_CRC && !short_pkt && (crc_calc != crc_rx_nx);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      video_o.tvalid <= 1'b0;
      video_o.tlast  <= 1'b0;
      video_o.tuser  <= 1'b0;
      video_o.tkeep  <= '0;
      video_o.tstrb  <= '0;
      video_o.tdata  <= '0;
      frame_active_o <= 1'b0;
      line_cnt_o     <= '0;
      crc_err_o      <= 1'b0;
      len_err_o      <= 1'b0;
      sof_pending    <= 1'b0;
      line_count     <= '0;
      bytes_left     <= '0;
      crc_reg        <= CRC_INIT;
      crc_rx         <= '0;
      crc_cnt        <= '0;
    end else begin
      video_o.tvalid <= beat_out;
      video_o.tlast  <= beat_out && out_last;
      video_o.tuser  <= beat_out && sof_pending;
      crc_err_o      <= pay_beat && pkt_i.tlast && crc_bad;
      len_err_o      <= pay_beat && pkt_i.tlast && short_pkt;
      if (beat_out) begin
        video_o.tdata <= pkt_i.tdata;
        video_o.tkeep <= data_en;
        video_o.tstrb <= data_en;
        sof_pending   <= 1'b0;
      end
      if (hdr_beat) begin
        if (pkt_i.tlast) begin
          if (hdr.dt == FRAME_START) begin
            frame_active_o <= 1'b1;
            sof_pending    <= 1'b1;
            line_count     <= '0;
          end else if (hdr.dt == FRAME_END) begin
            frame_active_o <= 1'b0;
            line_cnt_o     <= line_count;
          end
        end else begin
          bytes_left <= hdr.wc;
          crc_reg    <= CRC_INIT;
          crc_rx     <= '0;
          crc_cnt    <= '0;
        end
      end
      if (pay_beat) begin
        bytes_left <= bytes_left_nx;
        crc_reg    <= crc_calc;
        crc_rx     <= crc_rx_nx;
        crc_cnt    <= crc_cnt_nx;
        if (pkt_i.tlast) line_count <= line_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_csi2_payload_extractor.sv
// Scoreboard bench for csi2_payload_extractor: expected beats and error pulses are
// queued with their due cycle when stimulus is driven and matched as the DUT responds.
module tb_csi2_payload_extractor;
  import csi2_data_types_pkg::*;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } exp_beat_t;

  typedef struct {
    int   cyc;
    logic crc;
    logic len;
  } exp_err_t;

  logic        clk;
  logic        rst;
  logic        frame_active;
  logic [15:0] line_cnt;
  logic        crc_err;
  logic        len_err;

  axi4_stream_if pkt ();
  axi4_stream_if video ();

  exp_beat_t exp_q[$];
  exp_err_t  err_q[$];
  exp_beat_t mon_e;
  exp_err_t  mon_r;
  logic [7:0] pl_q[$];

  int cyc;
  int drive_cyc;
  int check_count;
  int pass_count;

  logic        sof_model;
  logic        frame_model;
  logic [15:0] line_model;
  logic [15:0] lcnt_model;

  csi2_payload_extractor #(
    .ACCEPT_DT (RAW10),
    .CHECK_CRC (1'b1)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .pkt_i          (pkt),
    .video_o        (video),
    .frame_active_o (frame_active),
    .line_cnt_o     (line_cnt),
    .crc_err_o      (crc_err),
    .len_err_o      (len_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Output beats and error pulses are matched against the queue fronts.
  always @(negedge clk) begin
    if (video.tvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_beat", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("beat_cycle", 32'(cyc), 32'(mon_e.cyc));
        check_output("tdata", video.tdata, mon_e.data);
        check_output("tkeep", 32'(video.tkeep), 32'(mon_e.keep));
        check_output("tstrb", 32'(video.tstrb), 32'(mon_e.keep));
        check_output("tlast", 32'(video.tlast), 32'(mon_e.last));
        check_output("tuser", 32'(video.tuser[0]), 32'(mon_e.user));
      end
    end
    if (err_q.size() != 0 && err_q[0].cyc == cyc) begin
      mon_r = err_q.pop_front();
      check_output("crc_err", 32'(crc_err), 32'(mon_r.crc));
      check_output("len_err", 32'(len_err), 32'(mon_r.len));
    end else if (crc_err === 1'b1 || len_err === 1'b1) begin
      check_output("spurious_err", {30'd0, crc_err, len_err}, 32'd0);
    end
  end

  function automatic logic [15:0] crc16_model(input logic [7:0] bytes_q[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (bytes_q[n]) begin
      c = c ^ {8'h00, bytes_q[n]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  task automatic send_beat(input logic [31:0] data, input logic last);
    @(negedge clk);
    pkt.tvalid = 1'b1;
    pkt.tdata  = data;
    pkt.tlast  = last;
    pkt.tkeep  = 4'hF;
    pkt.tstrb  = 4'hF;
    drive_cyc  = cyc;
  endtask

  task automatic idle();
    @(negedge clk);
    pkt.tvalid = 1'b0;
    pkt.tlast  = 1'b0;
  endtask

  task automatic fill_random(input int n);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic apply_stimulus_short(input logic [5:0] dt);
    send_beat({8'h00, 16'h0000, 2'b00, dt}, 1'b1);
    if (dt == FRAME_START) begin
      frame_model = 1'b1;
      sof_model   = 1'b1;
      line_model  = '0;
    end else if (dt == FRAME_END) begin
      frame_model = 1'b0;
      lcnt_model  = line_model;
    end
    idle();
    check_output("frame_active", 32'(frame_active), 32'(frame_model));
    check_output("line_cnt", 32'(line_cnt), 32'(lcnt_model));
  endtask

  // Long packet from pl_q; trunc >= 0 limits the bytes sent after the header.
  task automatic apply_stimulus_long(input logic [5:0] dt, input logic [15:0] wc,
                                     input logic [15:0] crc_rx, input int trunc);
    logic [7:0]  stream[$];
    logic [31:0] w;
    logic [3:0]  keep;
    int          nbytes, nbeats, nd;
    logic        acc, trunc_f, bad;
    exp_beat_t   e;
    exp_err_t    r;
    stream = pl_q;
    stream.push_back(crc_rx[7:0]);
    stream.push_back(crc_rx[15:8]);
    nbytes  = (trunc >= 0) ? trunc : stream.size();
    nbeats  = (nbytes + 3) / 4;
    trunc_f = (nbeats * 4) < (int'(wc) + 2);
    acc     = (dt == RAW10);
    bad     = !trunc_f && (crc16_model(pl_q) != crc_rx);
    send_beat({8'h00, wc, 2'b00, dt}, 1'b0);
    for (int k = 0; k < nbeats; k++) begin
      w = '0;
      for (int b = 0; b < 4; b++) if (4 * k + b < nbytes) w[8*b +: 8] = stream[4*k+b];
      send_beat(w, k == nbeats - 1);
      if (acc) begin
        nd = int'(wc) - 4 * k;
        if (nd > 4) nd = 4;
        if (nd > 0) begin
          keep   = 4'((1 << nd) - 1);
          e.cyc  = drive_cyc + 1;
          e.data = w;
          e.keep = keep;
          e.last = (4 * k + 4 >= int'(wc)) || (k == nbeats - 1 && trunc_f);
          e.user = sof_model;
          exp_q.push_back(e);
          sof_model = 1'b0;
        end
        if (k == nbeats - 1) begin
          r.cyc = drive_cyc + 1;
          r.crc = bad;
          r.len = trunc_f;
          err_q.push_back(r);
          line_model = line_model + 16'd1;
        end
      end
    end
    idle();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst        = 1'b1;
    pkt.tvalid = 1'b0;
    pkt.tlast  = 1'b0;
    sof_model   = 1'b0;
    frame_model = 1'b0;
    line_model  = '0;
    lcnt_model  = '0;
    @(negedge clk);
    rst = 1'b0;
    check_output("rst_tvalid", 32'(video.tvalid), 32'd0);
    check_output("rst_tlast", 32'(video.tlast), 32'd0);
    check_output("rst_tuser", 32'(video.tuser[0]), 32'd0);
    check_output("rst_tkeep", 32'(video.tkeep), 32'd0);
    check_output("rst_tdata", video.tdata, 32'd0);
    check_output("rst_frame_active", 32'(frame_active), 32'd0);
    check_output("rst_line_cnt", 32'(line_cnt), 32'd0);
    check_output("rst_crc_err", 32'(crc_err), 32'd0);
    check_output("rst_len_err", 32'(len_err), 32'd0);
    check_output("tready", 32'(pkt.tready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] w;
    exp_beat_t   e;
    cyc          = 0;
    check_count  = 0;
    pass_count   = 0;
    rst          = 1'b1;
    pkt.tvalid   = 1'b0;
    pkt.tlast    = 1'b0;
    pkt.tdata    = '0;
    pkt.tkeep    = '0;
    pkt.tstrb    = '0;
    pkt.tuser    = '0;
    video.tready = 1'b0;
    repeat (2) @(negedge clk);
    apply_reset();

    // Reference vector with good and corrupted CRC.
    apply_stimulus_short(FRAME_START);
    pl_q = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
             8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
    apply_stimulus_long(RAW10, 16'd24, 16'h00F0, -1);
    apply_stimulus_long(RAW10, 16'd24, 16'h00F1, -1);

    // Partial final beat and CRC split across beats.
    fill_random(5);
    apply_stimulus_long(RAW10, 16'd5, crc16_model(pl_q), -1);
    fill_random(7);
    apply_stimulus_long(RAW10, 16'd7, crc16_model(pl_q), -1);
    apply_stimulus_long(RAW10, 16'd7, crc16_model(pl_q) ^ 16'h0100, -1);
    pl_q.delete();
    apply_stimulus_long(RAW10, 16'd0, 16'hFFFF, -1);

    // Three lines with an embedded-data packet in between.
    apply_stimulus_short(FRAME_START);
    fill_random(8);
    apply_stimulus_long(RAW10, 16'd8, crc16_model(pl_q), -1);
    fill_random(8);
    apply_stimulus_long(6'h12, 16'd8, crc16_model(pl_q), -1);
    fill_random(12);
    apply_stimulus_long(RAW10, 16'd12, crc16_model(pl_q), -1);
    apply_stimulus_short(LINE_START);
    fill_random(8);
    apply_stimulus_long(RAW10, 16'd8, crc16_model(pl_q), -1);
    apply_stimulus_short(FRAME_END);

    // Truncated packet.
    fill_random(16);
    apply_stimulus_long(RAW10, 16'd16, crc16_model(pl_q), 8);

    // Reset in the middle of a payload, then a fresh frame.
    apply_stimulus_short(FRAME_START);
    fill_random(16);
    send_beat({8'h00, 16'd16, 2'b00, RAW10}, 1'b0);
    w = {pl_q[3], pl_q[2], pl_q[1], pl_q[0]};
    send_beat(w, 1'b0);
    e.cyc  = drive_cyc + 1;
    e.data = w;
    e.keep = 4'hF;
    e.last = 1'b0;
    e.user = 1'b1;
    exp_q.push_back(e);
    apply_reset();
    apply_stimulus_short(FRAME_START);
    fill_random(4);
    apply_stimulus_long(RAW10, 16'd4, crc16_model(pl_q), -1);
    apply_stimulus_short(FRAME_END);

    for (int i = 0; i < 20 && (exp_q.size() != 0 || err_q.size() != 0); i++) @(negedge clk);
    check_output("beats_outstanding", 32'(exp_q.size()), 32'd0);
    check_output("errs_outstanding", 32'(err_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
